serial_ctrl_slave: RTL and testbench

- Parametrised, single-clock successor to the USRP serial control-bus slave for the Cypress serial link.
- serial_clock and serial_enable are sampled in the master_clk domain.
- Frames are assembled in a shadow register and committed atomically on the closing edge of serial_enable.
- Adds aborted/overrun-frame detection, a read-access strobe and a configurable readback bank.

---
 rtl/serial_ctrl_pkg.sv | 25 ++
 rtl/serial_ctrl_slave_sync_edge.sv | 34 +++
 rtl/serial_ctrl_slave.sv | 194 +++++++++++++++++++
 tb/tb_serial_ctrl_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_ctrl_pkg.sv
// rtl/serial_ctrl_pkg.sv - shared types, sizes and helpers for the serial control-bus slave
package serial_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

  // Frame geometry at the default widths (7-bit address, 32-bit data).
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;
  localparam int HDR_W      = DEF_ADDR_W + 1;
  localparam int FRAME_LEN  = HDR_W + DEF_DATA_W;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_ctrl_slave_sync_edge.sv
// rtl/serial_ctrl_slave_sync_edge.sv - 2-flop synchroniser with single-cycle rise/fall pulses
//   clk      in   sampling clock
//   reset_n  in   asynchronous active-low reset
//   async_in in   asynchronous level to synchronise
//   rise     out  one-cycle pulse on a synchronised 0->1 transition
//   fall     out  one-cycle pulse on a synchronised 1->0 transition
module sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/serial_ctrl_slave.sv
// rtl/serial_ctrl_slave.sv - serial control-bus slave with atomic write commit and readback bank
//   master_clk      in   system clock (>= 8x serial_clock)
//   reset_n         in   asynchronous active-low reset
//   serial_clock    in   serial bit clock (asynchronous)
//   serial_enable   in   frame enable, active high (asynchronous)
//   serial_data_in  in   serial data from master, MSB first
//   serial_data_out out  readback bit, valid while serial_data_oe
//   serial_data_oe  out  pad output enable during reads
//   serial_addr     out  address of last committed write
//   serial_data     out  data of last committed write
//   serial_strobe   out  one-cycle pulse on write commit
//   read_strobe     out  one-cycle pulse when a read header completes
//   read_addr       out  address of the current read
//   frame_error     out  one-cycle pulse on aborted or overrun frame
//   readback_flat   in   readback words, word i at [i*DATA_W +: DATA_W]
module serial_ctrl_slave
  import serial_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int NUM_RB  = 8,
  parameter int RB_BASE = 1
) (
  input  logic                     master_clk,
  input  logic                     reset_n,
  input  logic                     serial_clock,
  input  logic                     serial_enable,
  input  logic                     serial_data_in,
  output logic                     serial_data_out,
  output logic                     serial_data_oe,
  output logic [ADDR_W-1:0]        serial_addr,
  output logic [DATA_W-1:0]        serial_data,
  output logic                     serial_strobe,
  output logic                     read_strobe,
  output logic [ADDR_W-1:0]        read_addr,
  output logic                     frame_error,
  input  logic [NUM_RB*DATA_W-1:0] readback_flat
);

  localparam int HDR_LEN = ADDR_W + 1;
  localparam int FRM_LEN = HDR_LEN + DATA_W;
  // Wide enough to hold the saturated overrun value FRM_LEN+1.
  localparam int CTR_W   = clog2(FRM_LEN + 2);

  localparam logic [CTR_W-1:0] CTR_HDR_LAST = CTR_W'(HDR_LEN - 1);
  localparam logic [CTR_W-1:0] CTR_HDR_DONE = CTR_W'(HDR_LEN);
  localparam logic [CTR_W-1:0] CTR_LAST     = CTR_W'(FRM_LEN - 1);
  localparam logic [CTR_W-1:0] CTR_FULL     = CTR_W'(FRM_LEN);
  localparam logic [CTR_W-1:0] CTR_SAT      = CTR_W'(FRM_LEN + 1);

  logic sclk_rise;
  logic sclk_fall;
  logic en_rise;
  logic en_fall;

  sync_edge u_sclk_sync (
    .clk      (master_clk),
    .reset_n  (reset_n),
    .async_in (serial_clock),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sync_edge u_en_sync (
    .clk      (master_clk),
    .reset_n  (reset_n),
    .async_in (serial_enable),
    .rise     (en_rise),
    .fall     (en_fall)
  );

  // Data goes through the same two-flop depth as the clock so that the bit
  // seen with sclk_rise is the one the master presented at that edge.
  logic din_meta;
  logic din_sync;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      din_meta <= 1'b0;
      din_sync <= 1'b0;
    end else begin
      din_meta <= serial_data_in;
      din_sync <= din_meta;
    end
  end

  state_t              state;
  logic [CTR_W-1:0]    bit_ctr;
  logic [HDR_LEN-2:0]  hdr_sr;
  logic [DATA_W-1:0]   wdata_sr;
  logic [DATA_W-1:0]   rd_sr;
  logic [ADDR_W-1:0]   shadow_addr;
  logic                is_read;

  logic [HDR_LEN-1:0]  hdr_next;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [DATA_W-1:0]   rb_word;

  always_comb begin
    hdr_next = {hdr_sr, din_sync};
    hdr_addr = hdr_next[ADDR_W-1:0];
    rb_word  = '0;
    for (int i = 0; i < NUM_RB; i++) begin
      if (int'(hdr_addr) == RB_BASE + i) rb_word = readback_flat[i*DATA_W +: DATA_W];
    end
  end

  assign serial_data_out = serial_data_oe & rd_sr[DATA_W-1];

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bit_ctr        <= '0;
      hdr_sr         <= '0;
      wdata_sr       <= '0;
      rd_sr          <= '0;
      shadow_addr    <= '0;
      is_read        <= 1'b0;
      serial_data_oe <= 1'b0;
      serial_addr    <= '0;
      serial_data    <= '0;
      serial_strobe  <= 1'b0;
      read_strobe    <= 1'b0;
      read_addr      <= '0;
      frame_error    <= 1'b0;
    end else begin
      serial_strobe <= 1'b0;
      read_strobe   <= 1'b0;
      frame_error   <= 1'b0;

      if (en_rise) begin
        // Also covers a re-assertion before the previous fall was seen.
        state          <= HDR;
        bit_ctr        <= '0;
        is_read        <= 1'b0;
        serial_data_oe <= 1'b0;
      end else if (en_fall) begin
        // en_fall takes priority, so a coincident sclk_rise is dropped.
        case (state)
          DONE: begin
            if (bit_ctr != CTR_FULL) begin
              frame_error <= 1'b1;
            end else if (!is_read) begin
              serial_addr   <= shadow_addr;
              serial_data   <= wdata_sr;
              serial_strobe <= 1'b1;
            end
          end
          HDR, WDATA, RDATA: frame_error <= 1'b1;
          default: ;
        endcase
        state          <= IDLE;
        serial_data_oe <= 1'b0;
      end else begin
        if (sclk_rise && state != IDLE && bit_ctr != CTR_SAT) bit_ctr <= bit_ctr + 1'b1;

        case (state)
          HDR: begin
            if (sclk_rise) begin
              hdr_sr <= hdr_next[HDR_LEN-2:0];
              if (bit_ctr == CTR_HDR_LAST) begin
                shadow_addr <= hdr_addr;
                if (hdr_next[HDR_LEN-1]) begin
                  state          <= RDATA;
                  is_read        <= 1'b1;
                  read_strobe    <= 1'b1;
                  read_addr      <= hdr_addr;
                  rd_sr          <= rb_word;
                  serial_data_oe <= 1'b1;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              wdata_sr <= {wdata_sr[DATA_W-2:0], din_sync};
              if (bit_ctr == CTR_LAST) state <= DONE;
            end
          end
          RDATA: begin
            // The fall right after the header keeps the MSB in place so the
            // master's first data rise samples it; later falls advance.
            if (sclk_fall && bit_ctr != CTR_HDR_DONE) rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
            if (sclk_rise && bit_ctr == CTR_LAST) state <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_ctrl_slave.sv
// tb/tb_serial_ctrl_slave.sv - scoreboard bench for serial_ctrl_slave (default and narrow builds)
module tb_serial_ctrl_slave;

  logic master_clk = 1'b0;
  logic reset_n;
  logic serial_clock;
  logic serial_enable;
  logic serial_data_in;

  logic         serial_data_out0, serial_data_oe0, serial_strobe0, read_strobe0, frame_error0;
  logic [6:0]   serial_addr0, read_addr0;
  logic [31:0]  serial_data0;
  logic [255:0] readback_flat0;

  logic         serial_data_out1, serial_data_oe1, serial_strobe1, read_strobe1, frame_error1;
  logic [4:0]   serial_addr1, read_addr1;
  logic [15:0]  serial_data1;
  logic [63:0]  readback_flat1;

  always #5 master_clk = ~master_clk;

  serial_ctrl_slave u_dut0 (
    .master_clk      (master_clk),
    .reset_n         (reset_n),
    .serial_clock    (serial_clock),
    .serial_enable   (serial_enable),
    .serial_data_in  (serial_data_in),
    .serial_data_out (serial_data_out0),
    .serial_data_oe  (serial_data_oe0),
    .serial_addr     (serial_addr0),
    .serial_data     (serial_data0),
    .serial_strobe   (serial_strobe0),
    .read_strobe     (read_strobe0),
    .read_addr       (read_addr0),
    .frame_error     (frame_error0),
    .readback_flat   (readback_flat0)
  );

  serial_ctrl_slave #(.ADDR_W(5), .DATA_W(16), .NUM_RB(4), .RB_BASE(1)) u_dut1 (
    .master_clk      (master_clk),
    .reset_n         (reset_n),
    .serial_clock    (serial_clock),
    .serial_enable   (serial_enable),
    .serial_data_in  (serial_data_in),
    .serial_data_out (serial_data_out1),
    .serial_data_oe  (serial_data_oe1),
    .serial_addr     (serial_addr1),
    .serial_data     (serial_data1),
    .serial_strobe   (serial_strobe1),
    .read_strobe     (read_strobe1),
    .read_addr       (read_addr1),
    .frame_error     (frame_error1),
    .readback_flat   (readback_flat1)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 = write commit, 1 = read header, 2 = frame error
  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  task automatic push_ev(input int kind, input logic [6:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [6:0] addr, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 64'(kind), 64'd99);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(kind), 64'(e.kind));
    if (kind == 0) check("commit_addr_data", {addr, data}, {e.addr, e.data});
    if (kind == 1) check("read_addr", addr, e.addr);
  endtask

  always @(negedge master_clk) begin
    if (reset_n) begin
      if (serial_strobe0) take(0, serial_addr0, serial_data0);
      if (read_strobe0)   take(1, read_addr0, 32'd0);
      if (frame_error0)   take(2, 7'd0, 32'd0);
    end
  end

  logic phase2 = 1'b0;
  int   n1_strobes = 0;
  int   n1_errors  = 0;

  always @(negedge master_clk) begin
    if (reset_n && phase2) begin
      if (serial_strobe1) n1_strobes++;
      if (frame_error1)   n1_errors++;
    end
  end

  task automatic wait_half();
    repeat (6) @(negedge master_clk);
  endtask

  // Drives one frame MSB first (frame bit flen-1 first) with nclk serial clocks.
  task automatic send_frame(input logic [63:0] frame, input int flen, input int nclk,
                            input int rst_at, output logic [31:0] rx,
                            output logic oe_hdr, output logic oe_dat, output int lat);
    rx = '0; oe_hdr = 1'b0; oe_dat = 1'b1; lat = 0;
    serial_enable = 1'b1;
    wait_half();
    for (int k = 0; k < nclk; k++) begin
      serial_data_in = (k < flen) ? frame[flen-1-k] : 1'b0;
      wait_half();
      if (k < 8) oe_hdr = oe_hdr | serial_data_oe0;
      else if (k < 40) begin
        oe_dat = oe_dat & serial_data_oe0;
        rx = {rx[30:0], serial_data_out0};
      end
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_oe", serial_data_oe0, 1'b0);
        check("rst_outputs", {serial_data_out0, serial_strobe0, read_strobe0, frame_error0,
                              serial_addr0, serial_data0, read_addr0}, 64'd0);
        serial_enable = 1'b0;
        serial_clock  = 1'b0;
        repeat (4) @(negedge master_clk);
        reset_n = 1'b1;
        repeat (8) @(negedge master_clk);
        return;
      end
      serial_clock = 1'b1;
      wait_half();
      serial_clock = 1'b0;
    end
    wait_half();
    serial_enable = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge master_clk);
      #1;
      if (serial_strobe0 && lat == 0) lat = i;
    end
    @(negedge master_clk);
  endtask

  logic [31:0] rx;
  logic        oe_hdr, oe_dat;
  int          lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; serial_clock = 1'b0; serial_enable = 1'b0; serial_data_in = 1'b0;
    for (int i = 0; i < 8; i++) readback_flat0[i*32 +: 32] = 32'hA500_0000 | i;
    readback_flat0[2*32 +: 32] = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) readback_flat1[i*16 +: 16] = 16'h5A00 | 16'(i);

    repeat (3) @(negedge master_clk);
    check("reset_outputs", {serial_data_oe0, serial_data_out0, serial_strobe0, read_strobe0,
                            frame_error0, serial_addr0, serial_data0, read_addr0}, 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge master_clk);

    // Write 15h / DEADBEEF
    push_ev(0, 7'h15, 32'hDEAD_BEEF);
    send_frame({24'd0, 1'b0, 7'h15, 32'hDEAD_BEEF}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("strobe_latency_3_to_4", (lat >= 3 && lat <= 4), 1'b1);
    check("write_addr", serial_addr0, 7'h15);
    check("write_data", serial_data0, 32'hDEAD_BEEF);

    // Read addr 3 -> word 2
    push_ev(1, 7'h03, 32'd0);
    send_frame({24'd0, 1'b1, 7'h03, 32'd0}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("read3_data", rx, 32'hCAFE_0001);
    check("read3_oe_in_header", oe_hdr, 1'b0);
    check("read3_oe_in_data", oe_dat, 1'b1);
    check("read3_oe_after", serial_data_oe0, 1'b0);
    check("read3_no_strobe", 64'(lat), 64'd0);

    // Out-of-range and below-base reads
    push_ev(1, 7'h40, 32'd0);
    send_frame({24'd0, 1'b1, 7'h40, 32'd0}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("read40_data", rx, 32'd0);
    push_ev(1, 7'h00, 32'd0);
    send_frame({24'd0, 1'b1, 7'h00, 32'd0}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("read0_data", rx, 32'd0);
    push_ev(1, 7'h08, 32'd0);
    send_frame({24'd0, 1'b1, 7'h08, 32'd0}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("read8_last_word", rx, 32'hA500_0007);

    // Abort after 20 clocks, then a normal write
    push_ev(2, 7'd0, 32'd0);
    send_frame({24'd0, 1'b0, 7'h33, 32'h1111_2222}, 40, 20, -1, rx, oe_hdr, oe_dat, lat);
    check("abort_keeps_addr", serial_addr0, 7'h15);
    check("abort_keeps_data", serial_data0, 32'hDEAD_BEEF);
    push_ev(0, 7'h2A, 32'h1234_5678);
    send_frame({24'd0, 1'b0, 7'h2A, 32'h1234_5678}, 40, 40, -1, rx, oe_hdr, oe_dat, lat);
    check("write2_latency", (lat >= 3 && lat <= 4), 1'b1);
    check("write2_out", {serial_addr0, serial_data0}, {7'h2A, 32'h1234_5678});

    // Overrun: 41 clocks
    push_ev(2, 7'd0, 32'd0);
    send_frame({24'd0, 1'b0, 7'h11, 32'h55AA_55AA}, 40, 41, -1, rx, oe_hdr, oe_dat, lat);
    check("overrun_no_strobe", 64'(lat), 64'd0);
    check("overrun_keeps_out", {serial_addr0, serial_data0}, {7'h2A, 32'h1234_5678});

    // Reset at bit 30 of a read
    push_ev(1, 7'h04, 32'd0);
    send_frame({24'd0, 1'b1, 7'h04, 32'd0}, 40, 40, 30, rx, oe_hdr, oe_dat, lat);
    check("post_reset_out", {serial_addr0, serial_data0, serial_data_oe0}, 64'd0);

    // Narrow build: 22-bit frame; the default build sees it as an aborted write
    phase2 = 1'b1;
    push_ev(2, 7'd0, 32'd0);
    send_frame({42'd0, 1'b0, 5'h0B, 16'hBEEF}, 22, 22, -1, rx, oe_hdr, oe_dat, lat);
    repeat (4) @(negedge master_clk);
    phase2 = 1'b0;
    check("narrow_strobes", 64'(n1_strobes), 64'd1);
    check("narrow_errors", 64'(n1_errors), 64'd0);
    check("narrow_addr", serial_addr1, 5'h0B);
    check("narrow_data", serial_data1, 16'hBEEF);

    repeat (10) @(negedge master_clk);
    check("events_outstanding", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
